// File: rtl/cr_huf_comp_ob_buf.sv
// Elastic output buffer behind the Huffman compressor outbound stream.
// Tracks TLV boundaries on delivered beats and keeps frame / stall statistics.
module cr_huf_comp_ob_buf #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  FTR_TYPE = 8'h09
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_tvalid,
    input  logic        in_tlast,
    input  logic        in_tid,
    input  logic [7:0]  in_tstrb,
    input  logic [7:0]  in_tuser,
    input  logic [63:0] in_tdata,
    output logic        in_tready,
    output logic        out_tvalid,
    output logic        out_tlast,
    output logic        out_tid,
    output logic [7:0]  out_tstrb,
    output logic [7:0]  out_tuser,
    output logic [63:0] out_tdata,
    input  logic        out_tready,
    input  logic        stat_clr,
    output logic        frame_done,
    output logic [23:0] frame_bytes,
    output logic [15:0] frame_cnt,
    output logic [31:0] stall_cycles,
    output logic        tlv_err,
    output logic        tlv_err_sticky
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 82;

    typedef enum logic [0:0] {
        EXP_HDR = 1'b0,
        IN_TLV  = 1'b1
    } tlv_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] in_entry_s;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ_s;
    logic [AW-1:0] rd_nxt_idx_s;
    logic          empty_s, full_s, push_s, pop_s;

    tlv_state_e    trk_q, trk_d;
    logic          cur_ftr_q, cur_ftr_d;
    logic          is_ftr_s;
    logic [23:0]   acc_q, acc_d;
    logic [24:0]   sum_s;
    logic [23:0]   acc_sat_s;
    logic [23:0]   frame_bytes_q, frame_bytes_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [31:0]   stall_q, stall_d;
    logic          frame_done_q, frame_done_d;
    logic          tlv_err_q, tlv_err_d;
    logic          sticky_q, sticky_d;

    assign in_entry_s   = {in_tlast, in_tid, in_tstrb, in_tuser, in_tdata};
    assign empty_s      = (wr_ptr_q == rd_ptr_q);
    assign full_s       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occ_s        = wr_ptr_q - rd_ptr_q;
    assign rd_nxt_idx_s = rd_ptr_q[AW-1:0] + AW'(1'b1);

    // in_tready depends only on registered pointers (and reset), never on out_tready.
    assign in_tready  = !rst && !full_s;
    assign out_tvalid = !empty_s;
    assign push_s     = in_tvalid && in_tready;
    assign pop_s      = out_tvalid && out_tready;

    assign {out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} = head_q;
    assign frame_done     = frame_done_q;
    assign frame_bytes    = frame_bytes_q;
    assign frame_cnt      = frame_cnt_q;
    assign stall_cycles   = stall_q;
    assign tlv_err        = tlv_err_q;
    assign tlv_err_sticky = sticky_q;

    // Pointer advance and head register refill (head always mirrors mem[rd]).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
            if (occ_s != PW'(1'b1)) begin
                head_d = mem_q[rd_nxt_idx_s];
            end else if (push_s) begin
                head_d = in_entry_s;
            end else begin
                head_d = head_q;
            end
        end else if (empty_s && push_s) begin
            head_d = in_entry_s;
        end else begin
            head_d = head_q;
        end
    end

    // TLV tracking, byte accounting and statistics, all advanced by pops.
    always_comb begin
        trk_d         = trk_q;
        cur_ftr_d     = cur_ftr_q;
        acc_d         = acc_q;
        frame_bytes_d = frame_bytes_q;
        frame_cnt_d   = frame_cnt_q;
        frame_done_d  = 1'b0;
        tlv_err_d     = 1'b0;
        is_ftr_s      = cur_ftr_q;
        sum_s         = {1'b0, acc_q} + {21'd0, popcount8(out_tstrb)};
        acc_sat_s     = sum_s[24] ? 24'hFFFFFF : sum_s[23:0];
        if (pop_s) begin
            case (trk_q)
                EXP_HDR: begin
                    // A header-less beat is taken as word 0 of a non-footer TLV.
                    is_ftr_s  = out_tuser[0] && (out_tdata[7:0] == FTR_TYPE);
                    tlv_err_d = !out_tuser[0];
                end
                IN_TLV: begin
                    if (out_tuser[0]) begin
                        is_ftr_s  = (out_tdata[7:0] == FTR_TYPE);
                        tlv_err_d = 1'b1;
                    end else begin
                        is_ftr_s  = cur_ftr_q;
                        tlv_err_d = 1'b0;
                    end
                end
                default: begin
                    is_ftr_s  = 1'b0;
                    tlv_err_d = 1'b1;
                end
            endcase
            cur_ftr_d = is_ftr_s;
            trk_d     = out_tlast ? EXP_HDR : IN_TLV;
            if (out_tlast && is_ftr_s) begin
                frame_bytes_d = acc_sat_s;
                acc_d         = 24'd0;
                frame_done_d  = 1'b1;
                frame_cnt_d   = frame_cnt_q + 16'd1;
            end else begin
                acc_d = acc_sat_s;
            end
        end else begin
            trk_d = trk_q;
        end
        if (stat_clr) begin
            frame_cnt_d = 16'd0;
        end else begin
            frame_cnt_d = frame_cnt_d;
        end
        sticky_d = sticky_q || tlv_err_d;
    end

    // Saturating stall counter; a clear wins over a coincident stall.
    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = 32'd0;
        end else if (out_tvalid && !out_tready && (stall_q != 32'hFFFFFFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // FIFO storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry_s;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            head_q        <= '0;
            trk_q         <= EXP_HDR;
            cur_ftr_q     <= 1'b0;
            acc_q         <= 24'd0;
            frame_bytes_q <= 24'd0;
            frame_cnt_q   <= 16'd0;
            stall_q       <= 32'd0;
            frame_done_q  <= 1'b0;
            tlv_err_q     <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            head_q        <= head_d;
            trk_q         <= trk_d;
            cur_ftr_q     <= cur_ftr_d;
            acc_q         <= acc_d;
            frame_bytes_q <= frame_bytes_d;
            frame_cnt_q   <= frame_cnt_d;
            stall_q       <= stall_d;
            frame_done_q  <= frame_done_d;
            tlv_err_q     <= tlv_err_d;
            sticky_q      <= sticky_d;
        end
    end

endmodule
